// File: rtl/mcp3008_responder.sv
// MCP3008 emulator: an SPI responder that oversamples AD_CLK/CS/DIN with clk,
// decodes the start/SGL/D2..D0 command and returns a 10-bit word taken from a
// parallel channel bus, MSB-first then LSB-first, as the real ADC does.
module mcp3008_responder #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ad_clk,
  input  logic        cs_n,
  input  logic        din,
  input  logic [79:0] ch_data,
  output logic        dout,
  output logic        dout_oe,
  output logic        conv_valid,
  output logic [2:0]  conv_ch,
  output logic        conv_diff,
  output logic        frame_abort
);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_START = 3'd1,
    ST_CMD        = 3'd2,
    ST_SAMPLE     = 3'd3,
    ST_SHIFT_MSB  = 3'd4,
    ST_SHIFT_LSB  = 3'd5,
    ST_TRAIL      = 3'd6
  } state_t;

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_din_sync;
  logic                   r_clk_prev;
  logic                   r_cs_prev;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [2:0]  r_cmd;
  logic        r_sampled;
  logic [9:0]  r_shift;

  logic        w_clk;
  logic        w_cs;
  logic        w_din;
  logic        w_cs_rise;
  logic        w_cs_fall;
  logic        w_sck_rise;
  logic        w_sck_fall;
  logic [2:0]  w_sel;
  logic [9:0]  w_sel_word;

  // Input synchronizers; reset to 0 so a cs_n held low through reset
  // never looks like a fall until it has been seen high first.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_sync <= '0;
      r_cs_sync  <= '0;
      r_din_sync <= '0;
      r_clk_prev <= 1'b0;
      r_cs_prev  <= 1'b0;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], ad_clk};
      r_cs_sync  <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
      r_din_sync <= {r_din_sync[SYNC_STAGES-2:0], din};
      r_clk_prev <= w_clk;
      r_cs_prev  <= w_cs;
    end
  end

  assign w_clk      = r_clk_sync[SYNC_STAGES-1];
  assign w_cs       = r_cs_sync[SYNC_STAGES-1];
  assign w_din      = r_din_sync[SYNC_STAGES-1];
  assign w_cs_rise  = w_cs & ~r_cs_prev;
  assign w_cs_fall  = ~w_cs & r_cs_prev;
  // SPI clock edges only count while the chip is selected.
  assign w_sck_rise = w_clk & ~r_clk_prev & ~w_cs;
  assign w_sck_fall = ~w_clk & r_clk_prev & ~w_cs;

  // r_cmd holds {SGL, D2, D1} by the D0 rise; D0 comes straight from din.
  assign w_sel = {r_cmd[1:0], w_din};

  // Channel word mux for the snapshot taken on the D0 rise.
  always_comb begin
    w_sel_word = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (3'(i) == w_sel) begin
        w_sel_word = ch_data[i*10 +: 10];
      end
    end
  end

  // Frame sequencer; a cs_n rise outranks any SPI clock edge in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_cmd       <= '0;
      r_sampled   <= 1'b0;
      r_shift     <= '0;
      dout        <= 1'b0;
      dout_oe     <= 1'b0;
      conv_valid  <= 1'b0;
      conv_ch     <= '0;
      conv_diff   <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      conv_valid  <= 1'b0;
      frame_abort <= 1'b0;
      if (r_state != ST_IDLE && w_cs_rise) begin
        r_state     <= ST_IDLE;
        dout        <= 1'b0;
        dout_oe     <= 1'b0;
        frame_abort <= (r_state == ST_CMD) || (r_state == ST_SAMPLE) ||
                       (r_state == ST_SHIFT_MSB);
      end else begin
        case (r_state)
          ST_IDLE: begin
            dout    <= 1'b0;
            dout_oe <= 1'b0;
            r_cnt   <= '0;
            if (w_cs_fall) begin
              r_state <= ST_WAIT_START;
            end
          end
          ST_WAIT_START: begin
            if (w_sck_rise && w_din) begin
              r_state <= ST_CMD;
              r_cnt   <= '0;
            end
          end
          ST_CMD: begin
            if (w_sck_rise) begin
              r_cmd <= {r_cmd[1:0], w_din};
              r_cnt <= r_cnt + 4'd1;
              if (r_cnt == 4'd3) begin
                r_shift    <= w_sel_word;
                conv_ch    <= w_sel;
                conv_diff  <= ~r_cmd[2];
                conv_valid <= 1'b1;
                r_sampled  <= 1'b0;
                r_state    <= ST_SAMPLE;
              end
            end
          end
          ST_SAMPLE: begin
            if (w_sck_rise) begin
              r_sampled <= 1'b1;
            end else if (w_sck_fall && r_sampled) begin
              dout    <= 1'b0;
              dout_oe <= 1'b1;
              r_cnt   <= '0;
              r_state <= ST_SHIFT_MSB;
            end
          end
          ST_SHIFT_MSB: begin
            // Rotate rather than shift so the word is intact again for the
            // LSB-first tail after ten falls.
            if (w_sck_fall) begin
              dout    <= r_shift[9];
              r_shift <= {r_shift[8:0], r_shift[9]};
              r_cnt   <= r_cnt + 4'd1;
              if (r_cnt == 4'd9) begin
                r_cnt   <= '0;
                r_state <= ST_SHIFT_LSB;
              end
            end
          end
          ST_SHIFT_LSB: begin
            // B0 was the last MSB-first bit, so the tail starts at B1.
            if (w_sck_fall) begin
              dout    <= r_shift[1];
              r_shift <= {1'b0, r_shift[9:1]};
              r_cnt   <= r_cnt + 4'd1;
              if (r_cnt == 4'd8) begin
                r_cnt   <= '0;
                r_state <= ST_TRAIL;
              end
            end
          end
          ST_TRAIL: begin
            if (w_sck_fall) begin
              dout    <= 1'b0;
              dout_oe <= 1'b1;
            end
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mcp3008_responder.sv
// Directed bench for mcp3008_responder: drives SPI frames from one initial
// block and checks returned bits against hand-computed words.
module tb_mcp3008_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        ad_clk;
  logic        cs_n;
  logic        din;
  logic [79:0] ch_data;
  logic        dout;
  logic        dout_oe;
  logic        conv_valid;
  logic [2:0]  conv_ch;
  logic        conv_diff;
  logic        frame_abort;

  int n_cmp   = 0;
  int n_fail  = 0;
  int n_valid = 0;
  int n_abort = 0;

  mcp3008_responder #(.SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .ad_clk     (ad_clk),
    .cs_n       (cs_n),
    .din        (din),
    .ch_data    (ch_data),
    .dout       (dout),
    .dout_oe    (dout_oe),
    .conv_valid (conv_valid),
    .conv_ch    (conv_ch),
    .conv_diff  (conv_diff),
    .frame_abort(frame_abort)
  );

  always #10 clk = ~clk;

  // Pulse counters for conv_valid / frame_abort.
  always @(negedge clk) begin
    if (conv_valid === 1'b1) n_valid++;
    if (frame_abort === 1'b1) n_abort++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: observed no finish, expected finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SPI clock: din set in the low phase, dout sampled just before the rise.
  task automatic spi_bit(input logic b, output logic o_d, output logic o_oe);
    din = b;
    tick(3);
    o_d  = dout;
    o_oe = dout_oe;
    ad_clk = 1'b1;
    tick(6);
    ad_clk = 1'b0;
    tick(3);
  endtask

  task automatic start_frame();
    cs_n = 1'b0;
    tick(6);
  endtask

  task automatic end_frame();
    cs_n = 1'b1;
    tick(8);
  endtask

  // Leading zeros, start, SGL, D2..D0 and the sample clock.
  task automatic send_cmd(input logic sgl, input logic [2:0] ch, input int nlead,
                          input logic exp_valid, input logic do_swap,
                          input logic [9:0] swap_word);
    logic d, o, oe_before;
    int k;
    for (int i = 0; i < nlead; i++) spi_bit(1'b0, d, o);
    spi_bit(1'b1, d, o);
    spi_bit(sgl, d, o);
    spi_bit(ch[2], d, o);
    spi_bit(ch[1], d, o);
    din = ch[0];
    tick(3);
    ad_clk = 1'b1;
    k = 0;
    for (int c = 1; c <= 6; c++) begin
      tick(1);
      if (do_swap && k != 0 && c == k + 1) ch_data[int'(ch)*10 +: 10] = swap_word;
      if (conv_valid === 1'b1 && k == 0) k = c;
    end
    ad_clk = 1'b0;
    tick(3);
    chk("conv_valid_latency", 32'(k), exp_valid ? 32'd3 : 32'd0);
    din = 1'b0;
    tick(3);
    ad_clk = 1'b1;
    tick(6);
    ad_clk = 1'b0;
    tick(2);
    oe_before = dout_oe;
    tick(1);
    if (exp_valid) begin
      chk("null_oe_before", 32'(oe_before), 32'd0);
      chk("null_oe_at3", 32'(dout_oe), 32'd1);
      chk("null_dout", 32'(dout), 32'd0);
    end else begin
      chk("no_frame_oe", 32'(dout_oe), 32'd0);
    end
  endtask

  task automatic read_bits(input int n, output logic [31:0] d, output logic [31:0] oe);
    logic bd, bo;
    d  = '0;
    oe = '0;
    for (int i = 0; i < n; i++) begin
      spi_bit(1'b0, bd, bo);
      d[i]  = bd;
      oe[i] = bo;
    end
  endtask

  // Expected read stream: null, B9..B0, B1..B9, then zeros; bit k = k-th read.
  function automatic logic [31:0] model(input logic [9:0] w);
    logic [31:0] m;
    m = '0;
    for (int k = 0; k < 10; k++) m[1+k] = w[9-k];
    for (int j = 0; j < 9; j++) m[11+j] = w[1+j];
    return m;
  endfunction

  initial begin
    logic [31:0] d, oe, m;
    int v0, a0;

    rst = 1'b1; cs_n = 1'b1; ad_clk = 1'b0; din = 1'b0; ch_data = '0;
    tick(4);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_dout_oe", 32'(dout_oe), 32'd0);
    chk("rst_conv_valid", 32'(conv_valid), 32'd0);
    chk("rst_frame_abort", 32'(frame_abort), 32'd0);
    chk("rst_conv_ch", 32'(conv_ch), 32'd0);
    chk("rst_conv_diff", 32'(conv_diff), 32'd0);
    rst = 1'b0;
    tick(6);

    // Single-ended ch5 with 7 leading zeros.
    ch_data[50 +: 10] = 10'h2A5;
    v0 = n_valid;
    start_frame();
    send_cmd(1'b1, 3'd5, 7, 1'b1, 1'b0, 10'h0);
    read_bits(11, d, oe);
    end_frame();
    chk("ch5_bits", 32'(d[10:0]), 32'(11'b10100101010));
    chk("ch5_oe", 32'(oe[10:0]), 32'h7FF);
    chk("ch5_valid_count", 32'(n_valid - v0), 32'd1);
    chk("ch5_conv_ch", 32'(conv_ch), 32'd5);
    chk("ch5_conv_diff", 32'(conv_diff), 32'd0);

    // LSB-first tail on ch0 in differential mode.
    ch_data[0 +: 10] = 10'h301;
    start_frame();
    send_cmd(1'b0, 3'd0, 0, 1'b1, 1'b0, 10'h0);
    read_bits(23, d, oe);
    end_frame();
    chk("ch0_tail_bits", 32'(d[22:0]), 32'(23'b00011000000010000000110));
    chk("ch0_tail_oe", 32'(oe[22:0]), 32'h7FFFFF);
    chk("ch0_conv_diff", 32'(conv_diff), 32'd1);
    chk("ch0_conv_ch", 32'(conv_ch), 32'd0);

    // Abort after B6 on ch2, then a clean frame on ch2.
    ch_data[20 +: 10] = 10'h1C7;
    a0 = n_abort;
    start_frame();
    send_cmd(1'b1, 3'd2, 2, 1'b1, 1'b0, 10'h0);
    read_bits(5, d, oe);
    m = model(10'h1C7);
    chk("abort_partial_bits", 32'(d[4:0]), 32'(m[4:0]));
    cs_n = 1'b1;
    tick(2);
    chk("abort_oe_at2", 32'(dout_oe), 32'd1);
    tick(1);
    chk("abort_oe_at3", 32'(dout_oe), 32'd0);
    chk("abort_pulse", 32'(frame_abort), 32'd1);
    tick(8);
    chk("abort_count", 32'(n_abort - a0), 32'd1);
    start_frame();
    send_cmd(1'b1, 3'd2, 0, 1'b1, 1'b0, 10'h0);
    read_bits(11, d, oe);
    end_frame();
    chk("ch2_after_abort", 32'(d[10:0]), 32'(m[10:0]));
    chk("abort_count_after", 32'(n_abort - a0), 32'd1);

    // Snapshot: ch3 changes one cycle after conv_valid.
    ch_data[30 +: 10] = 10'h155;
    start_frame();
    send_cmd(1'b1, 3'd3, 1, 1'b1, 1'b1, 10'h0AA);
    read_bits(11, d, oe);
    end_frame();
    m = model(10'h155);
    chk("snapshot_held", 32'(d[10:0]), 32'(m[10:0]));
    chk("snapshot_bus_changed", 32'(ch_data[30 +: 10]), 32'h0AA);
    start_frame();
    send_cmd(1'b1, 3'd3, 0, 1'b1, 1'b0, 10'h0);
    read_bits(11, d, oe);
    end_frame();
    m = model(10'h0AA);
    chk("snapshot_next_frame", 32'(d[10:0]), 32'(m[10:0]));

    // Reset mid-frame with cs_n held low.
    ch_data[10 +: 10] = 10'h3F0;
    start_frame();
    send_cmd(1'b1, 3'd1, 0, 1'b1, 1'b0, 10'h0);
    read_bits(3, d, oe);
    v0 = n_valid;
    a0 = n_abort;
    rst = 1'b1;
    tick(2);
    chk("midrst_oe", 32'(dout_oe), 32'd0);
    chk("midrst_dout", 32'(dout), 32'd0);
    chk("midrst_conv_ch", 32'(conv_ch), 32'd0);
    rst = 1'b0;
    tick(4);
    send_cmd(1'b1, 3'd1, 0, 1'b0, 1'b0, 10'h0);
    read_bits(11, d, oe);
    tick(4);
    chk("cslow_oe_stays0", oe, 32'd0);
    chk("cslow_no_valid", 32'(n_valid - v0), 32'd0);
    chk("midrst_no_abort", 32'(n_abort - a0), 32'd0);
    end_frame();
    start_frame();
    send_cmd(1'b1, 3'd1, 0, 1'b1, 1'b0, 10'h0);
    read_bits(11, d, oe);
    end_frame();
    m = model(10'h3F0);
    chk("after_reset_frame", 32'(d[10:0]), 32'(m[10:0]));

    // Eight-channel scan, 32-clock frames.
    for (int i = 0; i < 8; i++) ch_data[i*10 +: 10] = 10'(100 * i);
    a0 = n_abort;
    for (int i = 0; i < 8; i++) begin
      start_frame();
      send_cmd(1'b1, 3'(i), 0, 1'b1, 1'b0, 10'h0);
      read_bits(26, d, oe);
      end_frame();
      m = model(10'(100 * i));
      chk("scan_word", 32'(d[10:0]), 32'(m[10:0]));
      chk("scan_conv_ch", 32'(conv_ch), 32'(i));
    end
    chk("scan_no_abort", 32'(n_abort - a0), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mcp3008_responder.md
# mcp3008_responder

Clock-domain-safe SPI responder that emulates an MCP3008 8-channel, 10-bit ADC on the `AD_CLK`/`CS`/`DIN`/`DOUT` pins. It decodes the start, SGL/DIFF and D2..D0 command bits and returns a 10-bit value taken from a parallel channel-data bus. It is used as a loopback target for the motor controller's ADC scanner, or to turn a second board into a scripted throttle/battery source. Every pin input is oversampled by `clk`; no logic runs on the SPI clock.

## Interface
- `SYNC_STAGES`, 2: flip-flop depth of the input synchronizers on `ad_clk`, `cs_n` and `din`. Minimum 2.
- `clk` input 1: system clock, 50 MHz.
- `rst` input 1: synchronous, active-high reset.
- `ad_clk` input 1: SPI clock from the initiator. Asynchronous to `clk`.
- `cs_n` input 1: chip select, active low. Asynchronous.
- `din` input 1: command bits from the initiator. Asynchronous.
- `ch_data` input 80: channel words. Channel i occupies bits [10i+9:10i].
- `dout` output 1: serial result.
- `dout_oe` output 1: drive enable for `dout`. When 0, the pad is high-Z.
- `conv_valid` output 1: one-cycle pulse when a command has been decoded.
- `conv_ch` output 3: decoded D2..D0. Held until the next `conv_valid`.
- `conv_diff` output 1: 1 when SGL/DIFF = 0. Held until the next `conv_valid`.
- `frame_abort` output 1: one-cycle pulse when `cs_n` rises before B0 has been driven.

## Operation
- Each of `ad_clk`, `cs_n` and `din` passes through a `SYNC_STAGES` synchronizer.
- Rise and fall events come from the synchronized `ad_clk` compared with its previous value.
- Rising edges:
  - A rise is counted only while synchronized `cs_n` = 0.
  - On a counted rise, `din` is sampled from its synchronized value in the same cycle.
- States: IDLE, WAIT_START, CMD, SAMPLE, SHIFT_MSB, SHIFT_LSB, TRAIL.
- IDLE:
  - `dout_oe` = 0.
  - A fall of `cs_n` goes to WAIT_START.
  - After reset, the block needs `cs_n` observed high before it accepts a fall. If `cs_n` is low at reset release, it stays in IDLE until `cs_n` goes high and then low again.
- WAIT_START:
  - A rise with `din` = 0 is a leading zero and is ignored. Any number is allowed.
  - A rise with `din` = 1 is the start bit. Go to CMD with the bit counter at 0.
- CMD:
  - The next four rises capture SGL, D2, D1 and D0 in that order.
  - On the D0 rise, in the same cycle:
    - snapshot the selected word `ch_data[10*{D2,D1,D0} +: 10]` into a 10-bit shift register;
    - update `conv_ch` and `conv_diff`;
    - pulse `conv_valid`;
    - go to SAMPLE.
  - Differential mode uses the same index. It does not subtract channels.
- SAMPLE:
  - The next rise is the sample clock.
  - On the fall after it, drive the null bit: `dout_oe` = 1, `dout` = 0. Go to SHIFT_MSB.
- SHIFT_MSB: the next 10 falls drive B9 down to B0.
- SHIFT_LSB:
  - Entered after B0.
  - The next 9 falls drive B1 up to B9, LSB-first. B0 is not repeated.
- TRAIL: every further fall drives `dout` = 0 with `dout_oe` = 1.
- `cs_n` rising in any state except IDLE:
  - return to IDLE next cycle with `dout_oe` = 0 and `dout` = 0;
  - pulse `frame_abort` only if the state was CMD, SAMPLE or SHIFT_MSB with B0 not yet driven.
- A `cs_n` rise and an `ad_clk` edge detected in the same cycle: the `cs_n` rise wins and the edge is discarded.
- Later changes to `ch_data` do not affect a frame already in progress. The snapshot is held.
- `rst` mid-frame gives IDLE immediately. The rest of the frame is ignored. No `frame_abort` pulse.

## Timing
- Reset values:
  - `dout` = 0, `dout_oe` = 0;
  - `conv_valid` = 0, `frame_abort` = 0;
  - `conv_ch` = 0, `conv_diff` = 0;
  - state IDLE, all counters and the shift register 0.
- Edge-to-output latency: `dout` and `dout_oe` change exactly `SYNC_STAGES` + 1 `clk` cycles after the `ad_clk` fall reaches the pin. With the default, that is 3 cycles.
- `conv_valid` asserts `SYNC_STAGES` + 1 cycles after the D0 rise.
- Input requirements on the initiator:
  - `ad_clk` high and low phases each at least `SYNC_STAGES` + 2 `clk` cycles;
  - `din` stable from at least 1 `clk` before the rise to 1 `clk` after it.
- The initiator samples `dout` on rising `ad_clk`. Bit n is valid from 3 `clk` after fall n until 3 `clk` after fall n+1.
- Minimum frame is 17 rises with no leading zeros: start + 4 command + sample + 11 read clocks. The 11 read clocks carry the null bit then B9..B0.

## Test plan
- Single-ended ch5 read:
  - Stimulus: `ch_data` ch5 = 10'h2A5; 7 leading zeros, then 1,1,1,0,1; clock out 11 bits.
  - Required: `conv_valid` once, `conv_ch` = 5, `conv_diff` = 0; `dout` sequence after the sample clock is 0,1,0,1,0,1,0,0,1,0,1.
- LSB-first tail:
  - Stimulus: ch0 = 10'h301, frame continued 12 extra clocks.
  - Required: MSB frame 0,1,1,0,0,0,0,0,0,0,1, then B1..B9 = 0,0,0,0,0,0,0,1,1, then 0,0,0.
- Abort:
  - Stimulus: `cs_n` rises after B6 on ch2.
  - Required: `frame_abort` pulses once, `dout_oe` = 0 three cycles later; the next full frame on ch2 returns the correct word.
- Snapshot:
  - Stimulus: ch3 changes from 10'h155 to 10'h0AA one cycle after `conv_valid`.
  - Required: 10'h155 is shifted out.
- Reset with `cs_n` low:
  - Stimulus: release `rst` while `cs_n` = 0, clock a full command.
  - Required: no `conv_valid` and `dout_oe` stays 0; after `cs_n` goes high then low, a valid frame works.
- Eight-channel scan:
  - Stimulus: channels 0..7 loaded with 100·i; 32-clock frames cycling D2..D0 as the motor controller's scanner does.
  - Required: each frame returns 100·i with no `frame_abort`.
